// File: rtl/quad_pkg.sv
// Shared types and constants for the quadratic-solver issue block.
// The default float width, the solver pipeline depth, the packed
// coefficient triple and the fork FSM state encoding live here.
package quad_pkg;

  localparam int QUAD_LATENCY = 91;
  localparam int QUAD_SIZE    = 32;

  typedef struct packed {
    logic [QUAD_SIZE-1:0] a;
    logic [QUAD_SIZE-1:0] b;
    logic [QUAD_SIZE-1:0] c;
  } quad_coef_t;

  typedef enum logic {
    FORK_IDLE,
    FORK_PARTIAL
  } fork_state_t;

endpackage

// File: rtl/axis_skid.sv
// Two-entry skid buffer for the root return path.
// Every accepted word is registered, so it shows up on the output one
// cycle after it is accepted. The input ready is a register that reflects
// "not full". This lets back-to-back words stream at one per cycle while
// the output is being drained.
module axis_skid #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sData,
  input  logic             i_sValid,
  output logic             o_sReady,
  output logic [WIDTH-1:0] o_mData,
  output logic             o_mValid,
  input  logic             i_mReady,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_head;
  logic [1:0]       r_count;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_tail;
  logic [1:0]       w_countNext;

  assign w_push      = i_sValid & r_ready;
  assign w_pop       = (r_count != 2'd0) & i_mReady;
  assign w_tail      = r_head ^ r_count[0];
  assign w_countNext = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // Occupancy, read pointer and the registered not-full ready
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
      r_ready <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= w_countNext;
      r_ready <= (w_countNext != 2'd2);
    end
  end

  // Data storage needs no reset; occupancy decides what is visible
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[w_tail] <= i_sData;
    end
  end

  assign o_sReady = r_ready;
  assign o_mValid = (r_count != 2'd0);
  assign o_mData  = r_mem[r_head];
  assign o_count  = r_count;

endmodule

// File: rtl/quad_issue.sv
// Issue/return wrapper around a pipelined quadratic solver.
// The fork side sends the a/b/c coefficients to three independent
// channels and accepts the packed problem only after all three have gone
// out. It also limits how many problems are in flight at once.
// The return side passes roots through a two-entry skid buffer. A root
// that has no matching in-flight problem is dropped, and this is flagged.
// Optional feature macro: QUAD_ISSUE_TAG_EN adds m_axis_out_tuser. This
// port carries a wrapping issue tag for each root.
module quad_issue
  import quad_pkg::*;
#(
  parameter int SIZE            = QUAD_SIZE,
  parameter int MAX_OUTSTANDING = 128
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic [3*SIZE-1:0]                    s_axis_coef_tdata,
  input  logic                                 s_axis_coef_tvalid,
  output logic                                 s_axis_coef_tready,
  output logic [SIZE-1:0]                      m_axis_a_tdata,
  output logic                                 m_axis_a_tvalid,
  input  logic                                 m_axis_a_tready,
  output logic [SIZE-1:0]                      m_axis_b_tdata,
  output logic                                 m_axis_b_tvalid,
  input  logic                                 m_axis_b_tready,
  output logic [SIZE-1:0]                      m_axis_c_tdata,
  output logic                                 m_axis_c_tvalid,
  input  logic                                 m_axis_c_tready,
  input  logic [SIZE-1:0]                      s_axis_root_tdata,
  input  logic                                 s_axis_root_tvalid,
  output logic                                 s_axis_root_tready,
  output logic [SIZE-1:0]                      m_axis_out_tdata,
  output logic                                 m_axis_out_tvalid,
  input  logic                                 m_axis_out_tready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
`ifdef QUAD_ISSUE_TAG_EN
  output logic [$clog2(MAX_OUTSTANDING)-1:0]   m_axis_out_tuser,
`endif
  output logic                                 err_unexpected
);

  localparam int              OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]   MAX_CNT = OW'(MAX_OUTSTANDING);

  fork_state_t   r_state;
  fork_state_t   w_stateNext;
  logic          r_aDone, r_bDone, r_cDone;
  logic          w_aDoneNext, w_bDoneNext, w_cDoneNext;
  logic          r_live;
  logic [OW-1:0] r_outstanding;
  logic          r_err;
  logic          w_credit;
  logic          w_aFire, w_bFire, w_cFire, w_coefFire;
  logic          w_rootFire, w_unexpected, w_outFire;
  logic          w_skidPush, w_skidReady, w_outValid;
  logic [1:0]    w_skidCount;

  // r_live gates all issue activity. It stays low until the first edge after reset is released.
  assign w_credit = r_live & (r_outstanding < MAX_CNT);

  assign m_axis_a_tdata  = s_axis_coef_tdata[3*SIZE-1 -: SIZE];
  assign m_axis_b_tdata  = s_axis_coef_tdata[2*SIZE-1 -: SIZE];
  assign m_axis_c_tdata  = s_axis_coef_tdata[SIZE-1:0];
  assign m_axis_a_tvalid = s_axis_coef_tvalid & w_credit & ~r_aDone;
  assign m_axis_b_tvalid = s_axis_coef_tvalid & w_credit & ~r_bDone;
  assign m_axis_c_tvalid = s_axis_coef_tvalid & w_credit & ~r_cDone;

  assign w_aFire = m_axis_a_tvalid & m_axis_a_tready;
  assign w_bFire = m_axis_b_tvalid & m_axis_b_tready;
  assign w_cFire = m_axis_c_tvalid & m_axis_c_tready;

  assign s_axis_coef_tready = w_credit & (r_aDone | w_aFire) & (r_bDone | w_bFire)
                              & (r_cDone | w_cFire);
  assign w_coefFire = s_axis_coef_tvalid & s_axis_coef_tready;

  // Fork FSM next state: the problem handshake clears everything; otherwise latch each channel's send
  always_comb begin
    w_stateNext = r_state;
    w_aDoneNext = r_aDone;
    w_bDoneNext = r_bDone;
    w_cDoneNext = r_cDone;
    if (w_coefFire) begin
      w_stateNext = FORK_IDLE;
      w_aDoneNext = 1'b0;
      w_bDoneNext = 1'b0;
      w_cDoneNext = 1'b0;
    end else begin
      if (w_aFire) w_aDoneNext = 1'b1;
      if (w_bFire) w_bDoneNext = 1'b1;
      if (w_cFire) w_cDoneNext = 1'b1;
      if (w_aFire | w_bFire | w_cFire) w_stateNext = FORK_PARTIAL;
    end
  end

  // Fork FSM state and per-channel done flags
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= FORK_IDLE;
      r_aDone <= 1'b0;
      r_bDone <= 1'b0;
      r_cDone <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_aDone <= w_aDoneNext;
      r_bDone <= w_bDoneNext;
      r_cDone <= w_cDoneNext;
    end
  end

  // Liveness flag that keeps every handshake closed while reset is held
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // A root is unexpected when every in-flight problem already has its root waiting in the skid buffer
  assign w_rootFire   = s_axis_root_tvalid & w_skidReady;
  assign w_unexpected = w_rootFire & ({{(OW-2){1'b0}}, w_skidCount} == r_outstanding);
  assign w_skidPush   = s_axis_root_tvalid & ~w_unexpected;
  assign w_outFire    = w_outValid & m_axis_out_tready;

  axis_skid #(
    .WIDTH (SIZE)
  ) u_skid (
    .i_clk    (aclk),
    .i_rst    (areset),
    .i_sData  (s_axis_root_tdata),
    .i_sValid (w_skidPush),
    .o_sReady (w_skidReady),
    .o_mData  (m_axis_out_tdata),
    .o_mValid (w_outValid),
    .i_mReady (m_axis_out_tready),
    .o_count  (w_skidCount)
  );

  assign s_axis_root_tready = w_skidReady;
  assign m_axis_out_tvalid  = w_outValid;

  // In-flight count: up on problem accept, down on root delivery, unchanged when both happen
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_coefFire, w_outFire})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Sticky record of any dropped unexpected root
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_err <= 1'b0;
    else        r_err <= r_err | w_unexpected;
  end

  assign outstanding    = r_outstanding;
  assign err_unexpected = r_err;

`ifdef QUAD_ISSUE_TAG_EN
  localparam int TW = $clog2(MAX_OUTSTANDING);

  logic [TW-1:0] r_tag;
  logic [TW-1:0] r_tagWr;
  logic [TW-1:0] r_tagRd;
  logic [TW-1:0] r_tagMem [MAX_OUTSTANDING];

  // Tag counter and tag FIFO pointers. The tag is pushed at problem accept and popped when its root is delivered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tag   <= '0;
      r_tagWr <= '0;
      r_tagRd <= '0;
    end else begin
      if (w_coefFire) begin
        r_tag   <= r_tag + TW'(1);
        r_tagWr <= (r_tagWr == TW'(MAX_OUTSTANDING - 1)) ? '0 : r_tagWr + TW'(1);
      end
      if (w_outFire) begin
        r_tagRd <= (r_tagRd == TW'(MAX_OUTSTANDING - 1)) ? '0 : r_tagRd + TW'(1);
      end
    end
  end

  // Tag storage, written with the tag current at problem accept
  always_ff @(posedge aclk) begin
    if (w_coefFire) begin
      r_tagMem[r_tagWr] <= r_tag;
    end
  end

  assign m_axis_out_tuser = r_tagMem[r_tagRd];
`endif

endmodule

// File: doc/quad_issue.md
QUAD_ISSUE -- requirements
Module: quad_issue

Interface
REQ-001 Parameter SIZE, default 32, float word width in bits.
REQ-002 Parameter MAX_OUTSTANDING, default 128, maximum number of issued, unreturned problems; SHALL be >= 92.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 aclk  in  1  sole clock; all state changes on its rising edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 s_axis_coef_tdata  in  3*SIZE  packed {a,b,c}, with a in the MSBs; s_axis_coef_tvalid in 1; s_axis_coef_tready out 1.
REQ-007 m_axis_a_tdata  out  SIZE, m_axis_a_tvalid out 1, m_axis_a_tready in 1: coefficient a to the solver; channels m_axis_b_* and m_axis_c_* are identical in form.
REQ-008 s_axis_root_tdata  in  SIZE, s_axis_root_tvalid in 1, s_axis_root_tready out 1: root returned by the solver.
REQ-009 m_axis_out_tdata  out  SIZE, m_axis_out_tvalid out 1, m_axis_out_tready in 1: root delivered downstream.
REQ-010 outstanding  out  $clog2(MAX_OUTSTANDING+1)  count of in-flight problems.
REQ-011 err_unexpected  out  1  sticky flag: a root arrived with no problem outstanding.

Function
REQ-012 Fork FSM states: IDLE (no channel sent) and PARTIAL (at least one of the a/b/c channels accepted, and not all of them).
REQ-013 m_axis_x_tvalid = s_axis_coef_tvalid & credit & ~x_done, for x in {a,b,c}; credit = (outstanding < MAX_OUTSTANDING).
REQ-014 m_axis_x_tdata SHALL be the corresponding field of s_axis_coef_tdata, combinationally.
REQ-015 x_done SHALL set on that channel's handshake.
REQ-016 s_axis_coef_tready = credit & (a_done|a_fire) & (b_done|b_fire) & (c_done|c_fire).
REQ-017 When all three channels accept in the same cycle, the coefficient handshake occurs in that cycle, with no PARTIAL visit.
REQ-018 On the coefficient handshake all x_done flags clear and the FSM returns to IDLE.
REQ-019 Each coefficient SHALL be sent exactly once per problem, and channel order is unconstrained.
REQ-020 outstanding SHALL increment on the coefficient handshake and decrement on the m_axis_out handshake; when both occur in the same cycle it is unchanged.
REQ-021 While credit is 0, no new m_axis_x_tvalid SHALL rise; a problem already in PARTIAL SHALL still complete.
REQ-022 Return path: a 2-entry skid buffer. s_axis_root_tready = ~full, registered. A root accepted in cycle N SHALL appear on m_axis_out in cycle N+1. Full throughput is 1 root per cycle while m_axis_out_tready=1.
REQ-023 A root accepted when outstanding == (number of entries in the skid buffer) SHALL be dropped and SHALL set err_unexpected; tready is unaffected.
REQ-024 Order SHALL be preserved: roots exit in arrival order.
REQ-025 A valid SHALL NOT drop, nor its data change, until the corresponding handshake.

Reset
REQ-026 While areset=1: all m_*_tvalid=0, s_axis_coef_tready=0, s_axis_root_tready=0, done flags=0, FSM=IDLE, outstanding=0, skid buffer empty, err_unexpected=0, tag counter=0.
REQ-027 Reset asserted mid-PARTIAL SHALL abandon that problem; no completion occurs after release.
REQ-028 In the first cycle after release, s_axis_root_tready SHALL be 1.

Configuration
REQ-029 Macro QUAD_ISSUE_TAG_EN, when defined, adds m_axis_out_tuser [$clog2(MAX_OUTSTANDING)]. A wrapping issue tag is assigned at the coefficient handshake and pushed into an internal tag FIFO of depth MAX_OUTSTANDING. The tag is popped alongside each root, and tuser is aligned with tdata.
REQ-030 When QUAD_ISSUE_TAG_EN is not defined, there is no tuser port, no tag FIFO and no tag counter; all other behaviour is identical.

Structure
REQ-031 Package quad_pkg SHALL hold: localparam QUAD_LATENCY=91, the default SIZE, and typedef quad_coef_t (packed struct {a,b,c}).
REQ-032 Sub-module axis_skid (2-entry skid buffer, parameterised width) SHALL implement the return path.

Verification
REQ-033 Coefficients {0x3F800000, 0xC0400000, 0x40000000}, with all readies high and a solver model returning 0x3F800000 after 91 cycles -> one handshake on each channel in the same cycle; out = 0x3F800000 at cycle 92; outstanding goes 0->1->0.
REQ-034 m_axis_b_tready held low 5 cycles, a/c ready -> a and c fire once in cycle 0; FSM in PARTIAL; coef_tready=1 only in the cycle b fires; no repeated a/c handshakes.
REQ-035 Stream 200 problems with the solver stalled -> exactly MAX_OUTSTANDING=128 coefficient handshakes, then coef_tready=0; releasing 1 root restores 1 credit.
REQ-036 m_axis_out_tready=0 for 4 cycles during a burst of roots -> root tready deasserts after 2 accepts; no loss or reorder when ready returns.
REQ-037 Root injected with outstanding=0 -> dropped, err_unexpected=1 and sticky until areset.
REQ-038 areset asserted in PARTIAL, then released -> all outputs at reset values; the next problem issues all three channels afresh; with QUAD_ISSUE_TAG_EN defined, tags restart at 0.
